// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response bundle for alu_seq. The master side issues
//                operations (in_valid/A/B/sel) and consumes results
//                (out_ready); the slave side is the ALU itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             CF;
    logic             ZF;
    logic             NF;
    logic             VF;
    logic             illegal;

    modport master (
        output in_valid, A, B, sel, out_ready,
        input  in_ready, out_valid, out, CF, ZF, NF, VF, illegal
    );

    modport slave (
        input  in_valid, A, B, sel, out_ready,
        output in_ready, out_valid, out, CF, ZF, NF, VF, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked ALU. Base integer ops complete in one registered
//                cycle; with ALU_MULDIV_EN defined, unsigned MUL/MULHU/DIVU/
//                REMU run iteratively (one bit per cycle) in the EXEC state.
//                Without ALU_MULDIV_EN those codes report illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_seq_if.slave    bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] c_op_add   = 4'b0000;
    localparam logic [3:0] c_op_sll   = 4'b0001;
    localparam logic [3:0] c_op_sub   = 4'b0010;
    localparam logic [3:0] c_op_passb = 4'b0011;
    localparam logic [3:0] c_op_xor   = 4'b0100;
    localparam logic [3:0] c_op_srl   = 4'b0101;
    localparam logic [3:0] c_op_or    = 4'b0110;
    localparam logic [3:0] c_op_and   = 4'b0111;
    localparam logic [3:0] c_op_sra   = 4'b1000;
    localparam logic [3:0] c_op_slt   = 4'b1001;
    localparam logic [3:0] c_op_sltu  = 4'b1010;
    localparam logic [3:0] c_op_mul   = 4'b1011;
    localparam logic [3:0] c_op_mulhu = 4'b1100;
    localparam logic [3:0] c_op_divu  = 4'b1101;
    localparam logic [3:0] c_op_remu  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_cf, r_zf, r_nf, r_vf, r_ill;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_cf, w_vf, w_ill, w_muldiv;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_sum    = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_dif    = {1'b0, bus.A} - {1'b0, bus.B};
    assign w_shamt  = bus.B[SHW-1:0];

    // Single-cycle result and flag decode straight from the request operands.
    always_comb begin
        w_res    = '0;
        w_cf     = 1'b0;
        w_vf     = 1'b0;
        w_ill    = 1'b0;
        w_muldiv = 1'b0;
        case (bus.sel)
            c_op_add: begin
                w_res = w_sum[MSB:0];
                w_cf  = w_sum[WIDTH];
                w_vf  = (bus.A[MSB] == bus.B[MSB]) && (w_sum[MSB] != bus.A[MSB]);
            end
            c_op_sub: begin
                w_res = w_dif[MSB:0];
                w_cf  = w_dif[WIDTH];
                w_vf  = (bus.A[MSB] != bus.B[MSB]) && (w_dif[MSB] != bus.A[MSB]);
            end
            c_op_sll:   w_res = bus.A << w_shamt;
            c_op_passb: w_res = bus.B;
            c_op_xor:   w_res = bus.A ^ bus.B;
            c_op_srl:   w_res = bus.A >> w_shamt;
            c_op_or:    w_res = bus.A | bus.B;
            c_op_and:   w_res = bus.A & bus.B;
            c_op_sra:   w_res = $unsigned($signed(bus.A) >>> w_shamt);
            c_op_slt:   w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            c_op_sltu:  w_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            c_op_mul, c_op_mulhu, c_op_divu, c_op_remu: begin
`ifdef ALU_MULDIV_EN
                w_muldiv = 1'b1;
`else
                w_ill    = 1'b1;
`endif
            end
            default:    w_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [SHW-1:0] c_cnt_last = SHW'(WIDTH - 1);

    // Shared iteration registers: product high/low for multiply,
    // partial remainder/quotient for divide.
    logic [WIDTH-1:0] r_hi, r_lo, r_b;
    logic             r_div, r_want_hi;
    logic [SHW-1:0]   r_cnt;

    logic [WIDTH:0]   w_msum;
    logic [WIDTH:0]   w_rs;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_hi_nx, w_lo_nx, w_fin;

    assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_rs   = {r_hi, r_lo[MSB]};
    assign w_diff = w_rs - {1'b0, r_b};
    assign w_fin  = r_want_hi ? w_hi_nx : w_lo_nx;

    // One shift-add multiply step or one restoring-divide step per cycle.
    always_comb begin
        w_hi_nx = r_hi;
        w_lo_nx = r_lo;
        if (r_div) begin
            if (!w_diff[WIDTH]) begin
                w_hi_nx = w_diff[MSB:0];
                w_lo_nx = {r_lo[MSB-1:0], 1'b1};
            end else begin
                w_hi_nx = w_rs[MSB:0];
                w_lo_nx = {r_lo[MSB-1:0], 1'b0};
            end
        end else begin
            w_hi_nx = w_msum[WIDTH:1];
            w_lo_nx = {w_msum[0], r_lo[MSB:1]};
        end
    end
`endif

    // Control FSM plus registered result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_cf    <= 1'b0;
            r_zf    <= 1'b0;
            r_nf    <= 1'b0;
            r_vf    <= 1'b0;
            r_ill   <= 1'b0;
        end else if (w_accept) begin
`ifdef ALU_MULDIV_EN
            if (w_muldiv) begin
                r_state   <= ST_EXEC;
                r_hi      <= '0;
                r_lo      <= bus.A;
                r_b       <= bus.B;
                r_div     <= (bus.sel == c_op_divu) || (bus.sel == c_op_remu);
                r_want_hi <= (bus.sel == c_op_mulhu) || (bus.sel == c_op_remu);
                r_cnt     <= '0;
            end else
`endif
            begin
                r_state <= ST_DONE;
                r_out   <= w_res;
                r_cf    <= w_cf;
                r_zf    <= (w_res == '0);
                r_nf    <= w_res[MSB];
                r_vf    <= w_vf;
                r_ill   <= w_ill;
            end
        end else if (r_state == ST_DONE && bus.out_ready) begin
            r_state <= ST_IDLE;
        end
`ifdef ALU_MULDIV_EN
        else if (r_state == ST_EXEC) begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + 1'b1;
            // Last step lands its result directly in the output register.
            if (r_cnt == c_cnt_last) begin
                r_state <= ST_DONE;
                r_out   <= w_fin;
                r_cf    <= 1'b0;
                r_zf    <= (w_fin == '0);
                r_nf    <= w_fin[MSB];
                r_vf    <= 1'b0;
                r_ill   <= 1'b0;
            end
        end
`endif
    end

    assign bus.in_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE && bus.out_ready);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out       = r_out;
    assign bus.CF        = r_cf;
    assign bus.ZF        = r_zf;
    assign bus.NF        = r_nf;
    assign bus.VF        = r_vf;
    assign bus.illegal   = r_ill;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_seq;
    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit c_md = 1'b1;
`else
    localparam bit c_md = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Returns {illegal, CF, ZF, NF, VF, out[31:0]}.
    function automatic logic [36:0] model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, c_max, c_min;
        longint unsigned ua, ub;
        logic [31:0]     r;
        logic            cf, vf, ill;
        int              sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        c_max = 2147483647;
        c_min = -c_max - 1;
        sh = int'(b[4:0]);
        r = '0; cf = 0; vf = 0; ill = 0;
        case (s)
            4'd0:  begin r = 32'(ua + ub); cf = (ua + ub) > 64'hFFFF_FFFF;
                         vf = (sa + sb) > c_max || (sa + sb) < c_min; end
            4'd1:  r = a << sh;
            4'd2:  begin r = 32'(ua - ub); cf = ua < ub;
                         vf = (sa - sb) > c_max || (sa - sb) < c_min; end
            4'd3:  r = b;
            4'd4:  r = a ^ b;
            4'd5:  r = a >> sh;
            4'd6:  r = a | b;
            4'd7:  r = a & b;
            4'd8:  r = 32'(sa >>> sh);
            4'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd10: r = (ua < ub) ? 32'd1 : 32'd0;
            4'd11: if (c_md) r = 32'(ua * ub); else ill = 1;
            4'd12: if (c_md) r = 32'((ua * ub) >> 32); else ill = 1;
            4'd13: if (c_md) r = (ub == 0) ? 32'hFFFF_FFFF : 32'(ua / ub); else ill = 1;
            4'd14: if (c_md) r = (ub == 0) ? a : 32'(ua % ub); else ill = 1;
            default: ill = 1;
        endcase
        if (ill) r = '0;
        return {ill, cf, (r == 32'd0), r[31], vf, r};
    endfunction

    function automatic logic [4:0] obs_flags();
        return {bus.illegal, bus.CF, bus.ZF, bus.NF, bus.VF};
    endfunction

    task automatic run_op(input string tag, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [36:0] e;
        int          lat, exp_lat, n;
        e = model(s, a, b);
        exp_lat = (c_md && s >= 4'd11 && s <= 4'd14) ? W + 1 : 1;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.sel = s; bus.A = a; bus.B = b; bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
        if (!bus.in_ready) begin
            check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A = $urandom; bus.B = $urandom; bus.sel = 4'($urandom);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_out"}, 64'(bus.out), 64'(e[31:0]));
        check({tag, "_flags"}, 64'(obs_flags()), 64'(e[36:32]));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [36:0] e1, e2;
        logic [3:0]  s;
        logic [31:0] a, b;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.sel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", {bus.in_ready, bus.out_valid, bus.out, obs_flags()},
              {1'b1, 1'b0, 32'd0, 5'd0});

        // Directed cases
        run_op("add_wrap",  4'd0,  32'hFFFF_FFFF, 32'd1);
        check("add_wrap_const", {bus.out, obs_flags()}, {32'd0, 5'b01100});
        run_op("sub_neg",   4'd2,  32'd5, 32'd7);
        check("sub_neg_const", {bus.out, obs_flags()}, {32'hFFFF_FFFE, 5'b01010});
        run_op("sra_b21",   4'd8,  32'h8000_0000, 32'h21);
        check("sra_const", 64'(bus.out), 64'(32'hC000_0000));
        run_op("add_ovf",   4'd0,  32'h7FFF_FFFF, 32'd1);
        run_op("slt",       4'd9,  32'hFFFF_FFFF, 32'd1);
        run_op("sltu",      4'd10, 32'hFFFF_FFFF, 32'd1);
        run_op("mul",       4'd11, 32'h0001_0000, 32'h0001_0000);
        run_op("mulhu",     4'd12, 32'h0001_0000, 32'h0001_0000);
        run_op("divu_z",    4'd13, 32'd7, 32'd0);
        run_op("remu_z",    4'd14, 32'd7, 32'd0);
        run_op("divu",      4'd13, 32'd100, 32'd7);
        run_op("remu",      4'd14, 32'd100, 32'd7);
        run_op("rsvd",      4'd15, 32'h1234_5678, 32'h9ABC_DEF0);

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            s = 4'($urandom_range(0, 15));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op("rand", s, a, b);
        end

        // Back-to-back single-cycle ops at full rate
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s = 4'($urandom_range(0, 10));
            a = $urandom; b = $urandom;
            e1 = model(s, a, b);
            bus.in_valid = 1'b1; bus.sel = s; bus.A = a; bus.B = b;
            check("tput_ready", 64'(bus.in_ready), 64'd1);
            @(posedge clk);
            @(negedge clk);
            check("tput_out", {bus.out_valid, bus.out, obs_flags()}, {1'b1, e1[31:0], e1[36:32]});
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Backpressure with a pending request
        e1 = model(4'd0, 32'hA5A5_0001, 32'h0000_1111);
        e2 = model(4'd4, 32'h0F0F_0F0F, 32'hFFFF_0000);
        bus.in_valid = 1'b1; bus.sel = 4'd0; bus.A = 32'hA5A5_0001; bus.B = 32'h0000_1111;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.sel = 4'd4; bus.A = 32'h0F0F_0F0F; bus.B = 32'hFFFF_0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold", {bus.out_valid, bus.in_ready, bus.out, obs_flags()},
                  {1'b1, 1'b0, e1[31:0], e1[36:32]});
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp_next", {bus.out_valid, bus.out, obs_flags()}, {1'b1, e2[31:0], e2[36:32]});
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Reset during a long op (or a stalled result), with a request pending
        bus.in_valid = 1'b1; bus.sel = c_md ? 4'd13 : 4'd0;
        bus.A = 32'd1000; bus.B = 32'd3; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.sel = 4'd0; bus.A = 32'd1; bus.B = 32'd1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid", {bus.out_valid, bus.in_ready, bus.out, obs_flags()},
              {1'b0, 1'b1, 32'd0, 5'd0});
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_ignored_accept", {bus.out_valid, bus.out}, {1'b0, 32'd0});

        // Normal operation resumes after reset
        run_op("post_rst", 4'd6, 32'hF000_000F, 32'h0000_FF00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
